// File: rtl/bpred_pkg.sv
// Shared types and helpers for the bimodal/gshare branch predictor.
// Holds the sweep FSM states, index-mode encodings and counter/index helpers.
package bpred_pkg;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } bpred_state_e;

  localparam int MODE_BIMODAL = 0;
  localparam int MODE_GSHARE  = 1;
  localparam int CTR_MAX_BITS = 4;

  // Weakly-not-taken: MSB clear, every lower bit set (01, 011, 0111).
  function automatic logic [CTR_MAX_BITS-1:0] weak_nt_ctr(input int unsigned ctr_bits);
    logic [CTR_MAX_BITS-1:0] v;
    v = 4'd0;
    for (int unsigned b = 0; b < CTR_MAX_BITS; b++) begin
      if ((b + 32'd1) < ctr_bits) begin
        v[b] = 1'b1;
      end else begin
        v[b] = 1'b0;
      end
    end
    return v;
  endfunction

  function automatic logic [31:0] idx_hash(input logic [31:0] pc_idx,
                                           input logic [31:0] ghr,
                                           input int          mode);
    logic [31:0] h;
    if (mode == MODE_GSHARE) begin
      h = pc_idx ^ ghr;
    end else begin
      h = pc_idx;
    end
    return h;
  endfunction

endpackage

// File: rtl/sat_counter_update.sv
// Combinational next value of a W-bit saturating counter for one resolved outcome.
module sat_counter_update
  import bpred_pkg::*;
#(
  parameter int W = 2
) (
  input  logic [W-1:0] ctr_i,
  input  logic         taken_i,
  output logic [W-1:0] ctr_o
);

  localparam logic [W-1:0] CTR_ALL1 = {W{1'b1}};
  localparam logic [W-1:0] CTR_ZERO = {W{1'b0}};

  // Count toward the outcome, holding at the rails.
  always_comb begin
    ctr_o = ctr_i;
    if (taken_i) begin
      if (ctr_i != CTR_ALL1) begin
        ctr_o = ctr_i + W'(1);
      end else begin
        ctr_o = ctr_i;
      end
    end else begin
      if (ctr_i != CTR_ZERO) begin
        ctr_o = ctr_i - W'(1);
      end else begin
        ctr_o = ctr_i;
      end
    end
  end

endmodule

// File: rtl/gshare_bpred.sv
// Branch predictor: PHT of saturating counters (bimodal or gshare index) plus a
// tagged direct-mapped BTB, initialised by a reset-time sweep, with perf counters.
module gshare_bpred
  import bpred_pkg::*;
#(
  parameter int ENTRIES     = 1024,
  parameter int HIST_LEN    = 8,
  parameter int CTR_BITS    = 2,
  parameter int BTB_ENTRIES = 256,
  parameter int MODE        = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [31:0]                brn_addr_bpred_i,
  output logic                       brn_takeness_bpred_o,
  output logic [31:0]                brn_target_addr_bpred_o,
  output logic [$clog2(ENTRIES)-1:0] brn_idx_bpred_o,
  input  logic                       brn_ex_mem_bpred_i,
  input  logic [31:0]                brn_fdback_addr_bpred_i,
  input  logic [$clog2(ENTRIES)-1:0] brn_fdback_idx_bpred_i,
  input  logic                       brn_fdback_bpred_i,
  input  logic [31:0]                brn_btb_addr_bpred_i,
  input  logic                       brn_mispred_bpred_i,
  output logic                       ready_bpred_o,
  output logic [31:0]                upd_cnt_bpred_o,
  output logic [31:0]                mispred_cnt_bpred_o
);

  localparam int I     = $clog2(ENTRIES);
  localparam int B     = $clog2(BTB_ENTRIES);
  localparam int TAG_W = 32 - B - 2;
  localparam int SWEEP = (ENTRIES > BTB_ENTRIES) ? ENTRIES : BTB_ENTRIES;
  localparam int P_W   = $clog2(SWEEP);

  localparam logic [P_W-1:0]      P_LAST   = P_W'(SWEEP - 1);
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(weak_nt_ctr(CTR_BITS));

  bpred_state_e        state_q;
  logic [P_W-1:0]      p_q;
  logic                ready_q;
  logic [HIST_LEN-1:0] ghr_q, ghr_d, ghr_shift_s;
  logic [31:0]         upd_cnt_q, upd_cnt_d;
  logic [31:0]         mis_cnt_q, mis_cnt_d;

  logic [CTR_BITS-1:0] pht_q [ENTRIES];
  logic [BTB_ENTRIES-1:0] btb_vld_q;
  logic [TAG_W-1:0]    btb_tag_q [BTB_ENTRIES];
  logic [31:0]         btb_tgt_q [BTB_ENTRIES];

  logic                run_s, upd_s, btb_wr_s;
  logic                pht_in_range_s, btb_in_range_s;
  logic [I-1:0]        pc_idx_s, lkp_idx_s;
  logic [B-1:0]        lkp_btb_idx_s, fb_btb_idx_s;
  logic [TAG_W-1:0]    lkp_tag_s, fb_tag_s;
  logic                btb_hit_s, lkp_taken_s;
  logic [CTR_BITS-1:0] fb_ctr_s, ctr_next_s;
  logic                unused_pc_lsb_s;

  assign run_s          = (state_q == ST_RUN);
  assign upd_s          = run_s & brn_ex_mem_bpred_i;
  assign btb_wr_s       = upd_s & brn_fdback_bpred_i;
  assign pht_in_range_s = (32'(p_q) < 32'(ENTRIES));
  assign btb_in_range_s = (32'(p_q) < 32'(BTB_ENTRIES));
  assign unused_pc_lsb_s = ^{brn_addr_bpred_i[1:0], brn_fdback_addr_bpred_i[1:0]};

  // Lookup path: index hash, BTB tag check, prediction gated by RUN.
  assign pc_idx_s      = brn_addr_bpred_i[I+1:2];
  assign lkp_idx_s     = I'(idx_hash(32'(pc_idx_s), 32'(ghr_q), MODE));
  assign lkp_btb_idx_s = brn_addr_bpred_i[B+1:2];
  assign lkp_tag_s     = brn_addr_bpred_i[31:B+2];
  assign btb_hit_s     = btb_vld_q[lkp_btb_idx_s] && (btb_tag_q[lkp_btb_idx_s] == lkp_tag_s);
  assign lkp_taken_s   = run_s & pht_q[lkp_idx_s][CTR_BITS-1] & btb_hit_s;

  assign brn_takeness_bpred_o    = lkp_taken_s;
  assign brn_target_addr_bpred_o = lkp_taken_s ? btb_tgt_q[lkp_btb_idx_s] : 32'd0;
  assign brn_idx_bpred_o         = lkp_idx_s;

  assign fb_btb_idx_s = brn_fdback_addr_bpred_i[B+1:2];
  assign fb_tag_s     = brn_fdback_addr_bpred_i[31:B+2];
  assign fb_ctr_s     = pht_q[brn_fdback_idx_bpred_i];

  sat_counter_update #(
    .W(CTR_BITS)
  ) u_ctr_upd (
    .ctr_i  (fb_ctr_s),
    .taken_i(brn_fdback_bpred_i),
    .ctr_o  (ctr_next_s)
  );

  if (HIST_LEN == 1) begin : g_hist1
    assign ghr_shift_s = brn_fdback_bpred_i;
  end else begin : g_histn
    assign ghr_shift_s = {ghr_q[HIST_LEN-2:0], brn_fdback_bpred_i};
  end

  // Init sweep FSM: walk p over both tables once, then stay in RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_INIT;
      p_q     <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (p_q == P_LAST) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end else begin
            p_q <= p_q + P_W'(1);
          end
        end
        ST_RUN: begin
          state_q <= ST_RUN;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= ST_INIT;
          p_q     <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign ready_bpred_o = ready_q;

  // History and perf counters advance only on accepted updates.
  always_comb begin
    ghr_d     = ghr_q;
    upd_cnt_d = upd_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (upd_s) begin
      ghr_d     = ghr_shift_s;
      upd_cnt_d = upd_cnt_q + 32'd1;
      if (brn_mispred_bpred_i) begin
        mis_cnt_d = mis_cnt_q + 32'd1;
      end else begin
        mis_cnt_d = mis_cnt_q;
      end
    end else begin
      ghr_d     = ghr_q;
      upd_cnt_d = upd_cnt_q;
      mis_cnt_d = mis_cnt_q;
    end
  end

  // History and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ghr_q     <= '0;
      upd_cnt_q <= 32'd0;
      mis_cnt_q <= 32'd0;
    end else begin
      ghr_q     <= ghr_d;
      upd_cnt_q <= upd_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign upd_cnt_bpred_o     = upd_cnt_q;
  assign mispred_cnt_bpred_o = mis_cnt_q;

  // PHT: sweep is the sole writer in INIT, the update port the sole writer in RUN.
  always_ff @(posedge clk) begin
    if (!run_s) begin
      if (pht_in_range_s) begin
        pht_q[p_q[I-1:0]] <= CTR_INIT;
      end
    end else if (brn_ex_mem_bpred_i) begin
      pht_q[brn_fdback_idx_bpred_i] <= ctr_next_s;
    end
  end

  // BTB valid bits: cleared by reset and by the sweep, set by taken updates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btb_vld_q <= '0;
    end else if (!run_s) begin
      if (btb_in_range_s) begin
        btb_vld_q[p_q[B-1:0]] <= 1'b0;
      end
    end else if (btb_wr_s) begin
      btb_vld_q[fb_btb_idx_s] <= 1'b1;
    end
  end

  // BTB payload needs no reset; it is only observed behind a valid bit.
  always_ff @(posedge clk) begin
    if (btb_wr_s) begin
      btb_tag_q[fb_btb_idx_s] <= fb_tag_s;
      btb_tgt_q[fb_btb_idx_s] <= brn_btb_addr_bpred_i;
    end
  end

endmodule

// File: tb/tb_gshare_bpred.sv
// Directed bench: a bimodal and a gshare instance (16-entry PHT, 8-entry BTB)
// driven by the same stimulus, each output checked against hand-derived values.
module tb_gshare_bpred;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc, fb_addr, btb_addr;
  logic [3:0]  fb_idx;
  logic        ex_mem, fb_taken, mispred;

  logic        b_tkn, b_rdy, g_tkn, g_rdy;
  logic [31:0] b_tgt, b_upd, b_mis, g_tgt, g_upd, g_mis;
  logic [3:0]  b_idx, g_idx;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  gshare_bpred #(.ENTRIES(16), .HIST_LEN(4), .CTR_BITS(2), .BTB_ENTRIES(8), .MODE(0)) u_bim (
    .clk(clk), .reset(reset), .brn_addr_bpred_i(pc),
    .brn_takeness_bpred_o(b_tkn), .brn_target_addr_bpred_o(b_tgt), .brn_idx_bpred_o(b_idx),
    .brn_ex_mem_bpred_i(ex_mem), .brn_fdback_addr_bpred_i(fb_addr), .brn_fdback_idx_bpred_i(fb_idx),
    .brn_fdback_bpred_i(fb_taken), .brn_btb_addr_bpred_i(btb_addr), .brn_mispred_bpred_i(mispred),
    .ready_bpred_o(b_rdy), .upd_cnt_bpred_o(b_upd), .mispred_cnt_bpred_o(b_mis));

  gshare_bpred #(.ENTRIES(16), .HIST_LEN(4), .CTR_BITS(2), .BTB_ENTRIES(8), .MODE(1)) u_gsh (
    .clk(clk), .reset(reset), .brn_addr_bpred_i(pc),
    .brn_takeness_bpred_o(g_tkn), .brn_target_addr_bpred_o(g_tgt), .brn_idx_bpred_o(g_idx),
    .brn_ex_mem_bpred_i(ex_mem), .brn_fdback_addr_bpred_i(fb_addr), .brn_fdback_idx_bpred_i(fb_idx),
    .brn_fdback_bpred_i(fb_taken), .brn_btb_addr_bpred_i(btb_addr), .brn_mispred_bpred_i(mispred),
    .ready_bpred_o(g_rdy), .upd_cnt_bpred_o(g_upd), .mispred_cnt_bpred_o(g_mis));

  task automatic upd(input logic [31:0] a, input logic [3:0] idx, input logic t,
                     input logic [31:0] tgt, input logic mis);
    fb_addr = a; fb_idx = idx; fb_taken = t; btb_addr = tgt; mispred = mis; ex_mem = 1'b1;
    @(posedge clk); #1;
    ex_mem = 1'b0; mispred = 1'b0;
  endtask

  task automatic look(input logic [31:0] a);
    @(negedge clk);
    pc = a;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 64 && !b_rdy; k++) @(posedge clk);
    #1;
    vec_cnt++; if (b_rdy !== 1'b1) begin err_cnt++; $display("FAIL ready_timeout: got %b want 1", b_rdy); end
  endtask

  task automatic sweep_check(input string tag);
    logic exp_rdy;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      exp_rdy = (k == 16);
      vec_cnt++; if (b_rdy !== exp_rdy || g_rdy !== exp_rdy) begin
        err_cnt++; $display("FAIL %s_ready_edge%0d: got %b/%b want %b", tag, k, b_rdy, g_rdy, exp_rdy);
      end
      if (k < 16) begin
        vec_cnt++; if (b_tkn !== 1'b0 || b_tgt !== 32'd0) begin
          err_cnt++; $display("FAIL %s_init_lookup%0d: got %b %h want 0 0", tag, k, b_tkn, b_tgt);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; pc = 32'h40; ex_mem = 1'b0; fb_addr = 32'd0; fb_idx = 4'd0;
    fb_taken = 1'b0; btb_addr = 32'd0; mispred = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    vec_cnt++; if (b_rdy !== 1'b0 || g_rdy !== 1'b0) begin err_cnt++; $display("FAIL rst_ready: got %b/%b want 0", b_rdy, g_rdy); end
    vec_cnt++; if (b_tkn !== 1'b0 || b_tgt !== 32'd0) begin err_cnt++; $display("FAIL rst_pred: got %b %h want 0 0", b_tkn, b_tgt); end
    vec_cnt++; if (b_upd !== 32'd0 || b_mis !== 32'd0) begin err_cnt++; $display("FAIL rst_cnt: got %0d %0d want 0 0", b_upd, b_mis); end
    @(negedge clk); reset = 1'b0;
    sweep_check("rst");
    look(32'h40);
    vec_cnt++; if (b_tkn !== 1'b0 || b_tgt !== 32'd0) begin err_cnt++; $display("FAIL run_cold_0x40: got %b %h want 0 0", b_tkn, b_tgt); end
    look(32'h7FC);
    vec_cnt++; if (g_tkn !== 1'b0 || g_tgt !== 32'd0) begin err_cnt++; $display("FAIL run_cold_0x7fc: got %b %h want 0 0", g_tkn, g_tgt); end
  endtask

  task automatic test_training();
    upd(32'h40, 4'd0, 1'b1, 32'h80, 1'b0);
    look(32'h40);
    vec_cnt++; if (b_tkn !== 1'b1) begin err_cnt++; $display("FAIL train_ctr10_taken: got %b want 1", b_tkn); end
    upd(32'h40, 4'd0, 1'b1, 32'h80, 1'b0);
    look(32'h40);
    vec_cnt++; if (b_tkn !== 1'b1 || b_tgt !== 32'h80) begin err_cnt++; $display("FAIL train_ctr11: got %b %h want 1 00000080", b_tkn, b_tgt); end
    vec_cnt++; if (b_idx !== 4'd0) begin err_cnt++; $display("FAIL train_bim_idx: got %h want 0", b_idx); end
    // gshare copy: GHR=0011 so 0x40 maps to untrained entry 3
    vec_cnt++; if (g_idx !== 4'd3 || g_tkn !== 1'b0) begin err_cnt++; $display("FAIL train_gsh: got idx %h tkn %b want 3 0", g_idx, g_tkn); end
  endtask

  task automatic test_hysteresis();
    upd(32'h40, 4'd0, 1'b0, 32'hDEAD0000, 1'b1);
    look(32'h40);
    vec_cnt++; if (b_tkn !== 1'b1 || b_tgt !== 32'h80) begin err_cnt++; $display("FAIL hyst_ctr10: got %b %h want 1 00000080", b_tkn, b_tgt); end
    upd(32'h40, 4'd0, 1'b0, 32'hDEAD0000, 1'b1);
    look(32'h40);
    vec_cnt++; if (b_tkn !== 1'b0 || b_tgt !== 32'd0) begin err_cnt++; $display("FAIL hyst_ctr01: got %b %h want 0 0", b_tkn, b_tgt); end
    // Taken via PC 0x44 raises PHT[0] without touching BTB[0]
    upd(32'h44, 4'd0, 1'b1, 32'h99C, 1'b0);
    look(32'h40);
    vec_cnt++; if (b_tkn !== 1'b1 || b_tgt !== 32'h80) begin err_cnt++; $display("FAIL hyst_btb_kept: got %b %h want 1 00000080", b_tkn, b_tgt); end
  endtask

  task automatic test_gshare();
    do_reset();
    wait_ready();
    upd(32'h100, 4'd5, 1'b1, 32'h200, 1'b0);
    upd(32'h100, 4'd5, 1'b1, 32'h200, 1'b0);
    upd(32'h100, 4'd5, 1'b0, 32'h200, 1'b0);
    upd(32'h100, 4'd5, 1'b1, 32'h200, 1'b0);
    look(32'h40);
    vec_cnt++; if (g_idx !== 4'hD) begin err_cnt++; $display("FAIL gsh_idx_0x40: got %h want d", g_idx); end
    vec_cnt++; if (b_idx !== 4'h0) begin err_cnt++; $display("FAIL bim_idx_0x40: got %h want 0", b_idx); end
    vec_cnt++; if (g_tkn !== 1'b0) begin err_cnt++; $display("FAIL gsh_tkn_0x40: got %b want 0", g_tkn); end
    look(32'h48);
    vec_cnt++; if (g_idx !== 4'hF) begin err_cnt++; $display("FAIL gsh_idx_0x48: got %h want f", g_idx); end
  endtask

  task automatic test_alias();
    do_reset();
    wait_ready();
    upd(32'h40, 4'd0, 1'b1, 32'h80, 1'b0);
    upd(32'h40, 4'd8, 1'b1, 32'h80, 1'b0);
    upd(32'h40, 4'd8, 1'b1, 32'h80, 1'b0);
    look(32'h60);
    vec_cnt++; if (b_idx !== 4'd8) begin err_cnt++; $display("FAIL alias_idx: got %h want 8", b_idx); end
    vec_cnt++; if (b_tkn !== 1'b0 || b_tgt !== 32'd0) begin err_cnt++; $display("FAIL alias_tag_miss: got %b %h want 0 0", b_tkn, b_tgt); end
    look(32'h40);
    vec_cnt++; if (b_tkn !== 1'b1 || b_tgt !== 32'h80) begin err_cnt++; $display("FAIL alias_tag_hit: got %b %h want 1 00000080", b_tkn, b_tgt); end
  endtask

  task automatic test_counters();
    do_reset();
    @(negedge clk);
    upd(32'h40, 4'd0, 1'b1, 32'h80, 1'b1);
    wait_ready();
    pc = 32'h40; #1;
    vec_cnt++; if (b_upd !== 32'd0 || b_mis !== 32'd0) begin err_cnt++; $display("FAIL init_upd_dropped: got %0d %0d want 0 0", b_upd, b_mis); end
    vec_cnt++; if (g_idx !== 4'd0) begin err_cnt++; $display("FAIL init_ghr_kept: got %h want 0", g_idx); end
    upd(32'h200, 4'd0, 1'b1, 32'h300, 1'b1);
    upd(32'h200, 4'd0, 1'b1, 32'h300, 1'b0);
    upd(32'h200, 4'd0, 1'b1, 32'h300, 1'b0);
    upd(32'h200, 4'd0, 1'b1, 32'h300, 1'b1);
    upd(32'h200, 4'd0, 1'b1, 32'h300, 1'b0);
    vec_cnt++; if (b_upd !== 32'd5 || b_mis !== 32'd2) begin err_cnt++; $display("FAIL cnt_bim: got %0d %0d want 5 2", b_upd, b_mis); end
    vec_cnt++; if (g_upd !== 32'd5 || g_mis !== 32'd2) begin err_cnt++; $display("FAIL cnt_gsh: got %0d %0d want 5 2", g_upd, g_mis); end
    look(32'h200);
    vec_cnt++; if (b_tkn !== 1'b1 || b_tgt !== 32'h300) begin err_cnt++; $display("FAIL pre_rst_pred: got %b %h want 1 00000300", b_tkn, b_tgt); end
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    vec_cnt++; if (b_rdy !== 1'b0 || b_upd !== 32'd0 || b_mis !== 32'd0) begin
      err_cnt++; $display("FAIL midrun_rst: got rdy %b cnt %0d %0d want 0 0 0", b_rdy, b_upd, b_mis);
    end
    vec_cnt++; if (b_tkn !== 1'b0) begin err_cnt++; $display("FAIL midrun_rst_pred: got %b want 0", b_tkn); end
    @(negedge clk); reset = 1'b0;
    sweep_check("resweep");
    look(32'h200);
    vec_cnt++; if (b_tkn !== 1'b0 || b_tgt !== 32'd0) begin err_cnt++; $display("FAIL resweep_pred: got %b %h want 0 0", b_tkn, b_tgt); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    pc = 32'h40;
    fb_addr = 32'h40; fb_idx = 4'd0; fb_taken = 1'b1; btb_addr = 32'h80; mispred = 1'b0; ex_mem = 1'b1;
    #1;
    vec_cnt++; if (b_tkn !== 1'b0 || b_tgt !== 32'd0) begin err_cnt++; $display("FAIL same_cycle_pre: got %b %h want 0 0", b_tkn, b_tgt); end
    @(posedge clk); #1;
    ex_mem = 1'b0;
    vec_cnt++; if (b_tkn !== 1'b1 || b_tgt !== 32'h80) begin err_cnt++; $display("FAIL same_cycle_post: got %b %h want 1 00000080", b_tkn, b_tgt); end
  endtask

  initial begin
    test_reset();
    test_training();
    test_hysteresis();
    test_gshare();
    test_alias();
    test_counters();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/gshare_bpred.md
# gshare_bpred

Parametrised successor to the single-level branch predictor. Each PHT entry is an N-bit saturating counter, indexed either bimodally or gshare-style (PC XOR global history). The direct-mapped BTB is tagged and has valid bits, and a reset-time sweep FSM initialises the tables. Lookup sits combinationally in fetch, next to the PC register; update arrives from the execute stage, where branches resolve. The block also keeps two performance counters.

## Interface
- ENTRIES, 1024: PHT entries; power of 2, ≥ 4.
- HIST_LEN, 8: global history bits; 1 ≤ HIST_LEN ≤ log2(ENTRIES).
- CTR_BITS, 2: counter width; 2..4.
- BTB_ENTRIES, 256: BTB entries; power of 2, ≤ ENTRIES.
- MODE, 1: 0 = bimodal index, 1 = gshare index.
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high.
- brn_addr_bpred_i  in  32  fetch PC.
- brn_takeness_bpred_o  out  1  predicted taken.
- brn_target_addr_bpred_o  out  32  predicted target.
- brn_idx_bpred_o  out  log2(ENTRIES)  PHT index used for this lookup; carried down the pipe.
- brn_ex_mem_bpred_i  in  1  update valid (resolved branch in EX).
- brn_fdback_addr_bpred_i  in  32  PC of the resolved branch.
- brn_fdback_idx_bpred_i  in  log2(ENTRIES)  carried lookup index.
- brn_fdback_bpred_i  in  1  actual outcome (1 = taken).
- brn_btb_addr_bpred_i  in  32  actual taken target.
- brn_mispred_bpred_i  in  1  pipeline detected mispredict.
- ready_bpred_o  out  1  init sweep done.
- upd_cnt_bpred_o  out  32  number of accepted updates.
- mispred_cnt_bpred_o  out  32  number of accepted mispredicts.

## Operation
- Index definitions:
  - I = log2(ENTRIES), B = log2(BTB_ENTRIES).
  - pc_idx = pc[I+1:2].
  - Lookup index = pc_idx when MODE = 0, otherwise pc_idx ^ zero-extended GHR.
  - BTB index = pc[B+1:2]; tag = pc[31:B+2].
- Prediction:
  - Taken = PHT[idx] MSB & BTB valid & tag match & state == RUN.
  - Target = BTB target when taken, else 0.
- FSM:
  - INIT (reset state): an init pointer p counts 0..max(ENTRIES, BTB_ENTRIES)−1.
  - Each INIT cycle writes PHT[p] = weakly-not-taken (MSB 0, remaining bits 1, i.e. 01 for 2-bit) when p < ENTRIES, and clears BTB valid[p] when p < BTB_ENTRIES.
  - On the last p the FSM moves to RUN.
  - RUN is held until reset.
- Update (RUN & brn_ex_mem_bpred_i):
  - PHT[brn_fdback_idx_bpred_i] increments saturating at all-ones if taken, decrements saturating at 0 if not.
  - If taken, the BTB entry at the feedback PC's index gets valid = 1, tag, and target = brn_btb_addr_bpred_i. A not-taken update leaves the BTB unchanged.
  - GHR ← {GHR[HIST_LEN−2:0], outcome}. History is non-speculative, updated only on resolution.
  - upd_cnt increments by 1; mispred_cnt increments when brn_mispred_bpred_i = 1. Both wrap modulo 2^32.
- Updates presented during INIT are dropped; counters and GHR are not touched.

## Timing
- Reset values:
  - State INIT, p = 0, GHR = 0, both performance counters 0.
  - ready_bpred_o = 0, brn_takeness_bpred_o = 0, brn_target_addr_bpred_o = 0.
  - brn_idx_bpred_o is a combinational function of the PC and GHR.
- ready_bpred_o rises max(ENTRIES, BTB_ENTRIES) rising edges after reset deasserts.
- Lookup has zero-cycle latency: combinational from brn_addr_bpred_i and current state.
- An update becomes visible to a lookup in the cycle after its edge.
- A lookup and update to the same index in the same cycle: the lookup returns the pre-update value.
- PHT write priority: the INIT sweep is the only writer in INIT, the update port is the only writer in RUN.
- Reset asserted mid-RUN: asynchronous return to INIT, all state reinitialised, the sweep restarts.

## Structure
- Shared package `bpred_pkg`: FSM state enum (INIT, RUN), MODE encodings, the weakly-not-taken counter constant function, and an index-hash function.
- One natural sub-module: `sat_counter_update` (combinational next-value for a CTR_BITS counter, given the outcome).
- PHT and BTB are flop arrays with an asynchronous read port.

## Test plan
- Reset sweep: ENTRIES=16, BTB_ENTRIES=8; release reset → ready = 0 for 16 cycles, then 1; any lookup returns taken = 0, target = 0.
- Training (MODE=0, ENTRIES=16): two taken updates on PC 0x40 with target 0x80 → counter 01→10→11; lookup 0x40 → taken = 1, target = 0x80, idx = 0.
- Hysteresis: after saturating at 11, one not-taken → 10, still predicts taken; a second not-taken → 01, predicts not-taken with target 0; BTB still valid.
- Gshare (MODE=1, HIST_LEN=4): updates with outcomes T,T,N,T → GHR = 4'b1101; lookup 0x40 → idx = 0x0 ^ 0xD = 0xD.
- BTB alias: BTB_ENTRIES=8; train 0x40 taken, then look up 0x60 (same BTB index, different tag) with its counter at 11 → taken = 0.
- Counters and reset: 5 updates, 2 flagged mispredict → upd_cnt = 5, mispred_cnt = 2; an update during INIT is not counted; reset pulse mid-RUN → counters 0, ready = 0, sweep repeats.
